mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory port between two requesters:
  - instruction fetch (IF), read-only;
  - data access (D), load/store, driven by the mem_re/mem_we control bits.
- Sits between the pipeline front-end/MEM stage and the memory.
- Serialises accesses with one transaction outstanding, and stalls the pipeline while a requester waits.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits; byte enables are DW/8 bits wide.
- MAX_D_STREAK, 4, number of consecutive D grants allowed while IF is waiting, before IF is forced to win.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  synchronous reset, active-low.
- if_req_i  in  1  IF request; held with if_addr_i until if_gnt_o.
- if_addr_i  in  AW  IF address.
- if_gnt_o  out  1  IF request accepted (1-cycle pulse).
- if_rvalid_o  out  1  IF read data valid (1-cycle pulse).
- if_rdata_o  out  DW  IF read data; 0 when if_rvalid_o=0.
- d_req_i  in  1  D request; held with payload until d_gnt_o.
- d_we_i  in  1  D write enable (1=store, 0=load).
- d_be_i  in  DW/8  D byte enables.
- d_addr_i  in  AW  D address.
- d_wdata_i  in  DW  D write data.
- d_gnt_o  out  1  D request accepted (1-cycle pulse).
- d_rvalid_o  out  1  D response (1-cycle pulse; load data or store acknowledge).
- d_rdata_o  out  DW  D load data; 0 when d_rvalid_o=0.
- mem_req_o  out  1  memory request; held until mem_gnt_i.
- mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1/DW/8/AW/DW  latched payload.
- mem_gnt_i  in  1  memory accepted the request.
- mem_rvalid_i  in  1  memory response; writes are acknowledged too.
- mem_rdata_i  in  DW  memory read data.
- stall_o  out  1  a request is pending but not yet granted.

Behaviour:
- FSM states: IDLE, REQ, WAIT. All state, payload, owner and streak registers update on the rising edge of clk_i.
- Reset, sampled while rst_ni=0:
  - state goes to IDLE, owner_q=IF, d_streak_q=0, payload registers=0;
  - all outputs are 0.
- Reset mid-transaction abandons the access. A later mem_rvalid_i belonging to it is ignored, because it arrives in IDLE.
- IDLE:
  - If any request is pending, select a winner, pulse its gnt_o combinationally in that same cycle, latch its payload and owner, and go to REQ.
  - IF payload is latched as we=0, be=all-ones, wdata=0.
- Arbitration:
  - D wins by default.
  - IF wins when only IF requests, or when both request and d_streak_q==MAX_D_STREAK.
- Streak counter:
  - On a D grant with if_req_i=1: d_streak_q increments, saturating at MAX_D_STREAK.
  - On a D grant with if_req_i=0: d_streak_q is cleared.
  - On any IF grant: d_streak_q is cleared.
- REQ: mem_req_o=1 with the latched payload. Go to WAIT on mem_gnt_i; otherwise stay with the payload stable.
- WAIT:
  - mem_req_o=0.
  - On mem_rvalid_i, forward a 1-cycle pulse combinationally to the owner's rvalid_o, with rdata_o=mem_rdata_i, and go to IDLE.
  - The non-owner sees rvalid_o=0 and rdata_o=0.
- mem_rvalid_i in IDLE or REQ is ignored (protocol error; the bench asserts it never occurs).
- Minimum latency: req at cycle 0 → gnt_o at cycle 0 → mem_req_o at cycle 1 → rvalid_o at cycle 2 at the earliest. Peak rate is one transaction per 3 cycles.
- stall_o = (if_req_i & ~if_gnt_o) | (d_req_i & ~d_gnt_o).
- Simultaneous events:
  - A requester dropping req before its gnt is legal; it is not granted.
  - Both requests arriving in IDLE produce exactly one gnt pulse.
  - A new request arriving in the same cycle as the owner's rvalid is arbitrated in the following IDLE cycle.

Decomposition:
- Shared package/header: state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2), owner encoding (OWN_IF=1'b0, OWN_D=1'b1), and DW/8 byte-enable width.
- The memory-interface payload bundle widths are shared with the LSU.
- No sub-module; the fixed-priority-with-streak-override selector is a few lines inline.

Test Plan:
- Only IF request, addr 0x100; memory gives gnt at cycle 1 and rvalid with 0xDEADBEEF at cycle 3 → if_gnt_o at cycle 0, mem_addr_o=0x100 with we=0 and be=4'hF, if_rvalid_o pulse at cycle 3 carrying 0xDEADBEEF, d_rvalid_o=0 throughout.
- IF and D request together, D is a store to 0x200 with wdata 0x12345678 and be=4'h3 → D granted first, mem_we_o=1, stall_o=1 until IF is granted after D's rvalid.
- D requests continuously (6 loads) with IF held high, MAX_D_STREAK=4 → exactly 4 D grants, then an IF grant, then D resumes; d_streak_q is 0 after the IF grant.
- mem_gnt_i held low for 5 cycles in REQ → mem_req_o and the payload stay stable for all 5 cycles, and no second gnt_o is issued.
- rst_ni asserted low in WAIT, then a late mem_rvalid_i arrives → outputs are 0 during reset, no rvalid_o pulse reaches either requester, and the FSM is IDLE.
- Stray mem_rvalid_i in IDLE → no rvalid_o pulse and no state change.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and memory-port widths for the IF/D memory port arbiter.
// The payload widths are also used by the LSU.
package mem_port_arbiter_pkg;

    localparam int unsigned MEM_AW  = 32;
    localparam int unsigned MEM_DW  = 32;
    localparam int unsigned MEM_BEW = MEM_DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (IF, D) and memory-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW = MEM_AW,
    parameter int unsigned DW = MEM_DW
);
    logic              if_req_i;
    logic [AW-1:0]     if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DW-1:0]     if_rdata_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [DW/8-1:0]   d_be_i;
    logic [AW-1:0]     d_addr_i;
    logic [DW-1:0]     d_wdata_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [DW-1:0]     d_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [DW/8-1:0]   mem_be_o;
    logic [AW-1:0]     mem_addr_o;
    logic [DW-1:0]     mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DW-1:0]     mem_rdata_i;

    logic              stall_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output stall_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  stall_o
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one
// transaction outstanding; D has priority unless IF has been starved too long.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW           = MEM_AW,
    parameter int unsigned DW           = MEM_DW,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    mem_port_arbiter_if.slave   bus
);

    localparam int unsigned BEW = DW / 8;
    localparam int unsigned SW  = $clog2(MAX_D_STREAK + 1);

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    logic [SW-1:0]   d_streak_q, d_streak_d;
    logic            we_q, we_d;
    logic [BEW-1:0]  be_q, be_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;

    logic if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, if_wins;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            d_streak_q <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            d_streak_q <= d_streak_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        d_streak_d = d_streak_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        if_rvalid  = 1'b0;
        d_rvalid   = 1'b0;
        mem_req    = 1'b0;
        if_wins    = 1'b0;

        // Everything is held quiet while reset is asserted, even mid-transaction.
        if (rst_ni) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.if_req_i || bus.d_req_i) begin
                        if_wins = bus.if_req_i &&
                                  (!bus.d_req_i || d_streak_q == SW'(MAX_D_STREAK));
                        state_d = REQ;
                        if (if_wins) begin
                            if_gnt     = 1'b1;
                            owner_d    = OWN_IF;
                            d_streak_d = '0;
                            we_d       = 1'b0;
                            be_d       = '1;
                            addr_d     = bus.if_addr_i;
                            wdata_d    = '0;
                        end else begin
                            d_gnt   = 1'b1;
                            owner_d = OWN_D;
                            we_d    = bus.d_we_i;
                            be_d    = bus.d_be_i;
                            addr_d  = bus.d_addr_i;
                            wdata_d = bus.d_wdata_i;
                            // Count D wins only while IF is actually being held off.
                            if (!bus.if_req_i) begin
                                d_streak_d = '0;
                            end else if (d_streak_q != SW'(MAX_D_STREAK)) begin
                                d_streak_d = d_streak_q + SW'(1);
                            end
                        end
                    end
                end
                REQ: begin
                    mem_req = 1'b1;
                    if (bus.mem_gnt_i) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid_i) begin
                        if (owner_q == OWN_IF) begin
                            if_rvalid = 1'b1;
                        end else begin
                            d_rvalid = 1'b1;
                        end
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.if_gnt_o    = if_gnt;
    assign bus.d_gnt_o     = d_gnt;
    assign bus.if_rvalid_o = if_rvalid;
    assign bus.d_rvalid_o  = d_rvalid;
    assign bus.if_rdata_o  = if_rvalid ? bus.mem_rdata_i : '0;
    assign bus.d_rdata_o   = d_rvalid  ? bus.mem_rdata_i : '0;

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = rst_ni ? we_q    : 1'b0;
    assign bus.mem_be_o    = rst_ni ? be_q    : '0;
    assign bus.mem_addr_o  = rst_ni ? addr_q  : '0;
    assign bus.mem_wdata_o = rst_ni ? wdata_q : '0;

    assign bus.stall_o = rst_ni &
                         ((bus.if_req_i & ~if_gnt) | (bus.d_req_i & ~d_gnt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change just after the rising
// edge, outputs are checked on the falling edge.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;
    logic stray_ok = 1'b0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(4)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    // Memory responses are only legal while a transaction is outstanding.
    always @(negedge clk_i) begin
        if (rst_ni && bus.mem_rvalid_i && !stray_ok && dut.state_q != WAIT) begin
            n_err++;
            $display("FAIL protocol: mem_rvalid_i in state %0d", dut.state_q);
        end
    end

    task automatic test_reset();
        rst_ni = 1'b0;
        bus.if_req_i = 1'b1;
        bus.d_req_i  = 1'b1;
        step();
        step();
        settle();
        n_vec++;
        if ({bus.if_gnt_o, bus.d_gnt_o, bus.if_rvalid_o, bus.d_rvalid_o, bus.mem_req_o, bus.stall_o} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got %b exp 000000",
                     {bus.if_gnt_o, bus.d_gnt_o, bus.if_rvalid_o, bus.d_rvalid_o, bus.mem_req_o, bus.stall_o});
        end
        n_vec++;
        if ({bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !== 69'd0) begin
            n_err++;
            $display("FAIL reset_payload got %h exp 0", {bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o});
        end
        n_vec++;
        if (dut.state_q !== IDLE || dut.d_streak_q !== 3'd0) begin
            n_err++;
            $display("FAIL reset_state got state=%0d streak=%0d exp 0/0", dut.state_q, dut.d_streak_q);
        end
        bus.if_req_i = 1'b0;
        bus.d_req_i  = 1'b0;
        step();
        rst_ni = 1'b1;
        $display("reset: done");
    endtask

    task automatic test_if_only();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h100;
        settle();
        n_vec++;
        if ({bus.if_gnt_o, bus.d_gnt_o, bus.stall_o} !== 3'b100) begin
            n_err++;
            $display("FAIL if_only_gnt got %b exp 100", {bus.if_gnt_o, bus.d_gnt_o, bus.stall_o});
        end
        step();
        bus.if_req_i  = 1'b0;
        bus.mem_gnt_i = 1'b1;
        settle();
        n_vec++;
        if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !== {1'b1, 1'b0, 4'hF, 32'h100, 32'h0}) begin
            n_err++;
            $display("FAIL if_only_payload got req=%b we=%b be=%h addr=%h wd=%h exp 1/0/f/100/0",
                     bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o);
        end
        step();
        bus.mem_gnt_i = 1'b0;
        settle();
        n_vec++;
        if ({bus.mem_req_o, bus.if_rvalid_o, bus.d_rvalid_o} !== 3'b000) begin
            n_err++;
            $display("FAIL if_only_wait got %b exp 000", {bus.mem_req_o, bus.if_rvalid_o, bus.d_rvalid_o});
        end
        step();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hDEADBEEF;
        settle();
        n_vec++;
        if ({bus.if_rvalid_o, bus.d_rvalid_o, bus.if_rdata_o, bus.d_rdata_o} !== {2'b10, 32'hDEADBEEF, 32'h0}) begin
            n_err++;
            $display("FAIL if_only_rvalid got v=%b if_rd=%h d_rd=%h exp 10/deadbeef/0",
                     {bus.if_rvalid_o, bus.d_rvalid_o}, bus.if_rdata_o, bus.d_rdata_o);
        end
        step();
        bus.mem_rvalid_i = 1'b0;
        settle();
        n_vec++;
        if ({bus.if_rvalid_o, bus.d_rvalid_o, bus.if_rdata_o} !== 34'd0 || dut.state_q !== IDLE) begin
            n_err++;
            $display("FAIL if_only_after got v=%b rd=%h state=%0d exp 00/0/IDLE",
                     {bus.if_rvalid_o, bus.d_rvalid_o}, bus.if_rdata_o, dut.state_q);
        end
        bus.mem_rdata_i = 32'h0;
        step();
        $display("if_only: fetch 0x100 -> 0xdeadbeef");
    endtask

    task automatic test_both();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h300;
        bus.d_req_i   = 1'b1;
        bus.d_we_i    = 1'b1;
        bus.d_be_i    = 4'h3;
        bus.d_addr_i  = 32'h200;
        bus.d_wdata_i = 32'h12345678;
        settle();
        n_vec++;
        if ({bus.if_gnt_o, bus.d_gnt_o, bus.stall_o} !== 3'b011) begin
            n_err++;
            $display("FAIL both_gnt got %b exp 011", {bus.if_gnt_o, bus.d_gnt_o, bus.stall_o});
        end
        step();
        bus.d_req_i = 1'b0; bus.d_we_i = 1'b0; bus.d_be_i = 4'h0;
        bus.d_addr_i = 32'h0; bus.d_wdata_i = 32'h0;
        bus.mem_gnt_i = 1'b1;
        settle();
        n_vec++;
        if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !== {1'b1, 1'b1, 4'h3, 32'h200, 32'h12345678}
            || {bus.if_gnt_o, bus.d_gnt_o, bus.stall_o} !== 3'b001) begin
            n_err++;
            $display("FAIL both_store got req=%b we=%b be=%h addr=%h wd=%h gs=%b exp 1/1/3/200/12345678/001",
                     bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o,
                     {bus.if_gnt_o, bus.d_gnt_o, bus.stall_o});
        end
        step();
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h55;
        settle();
        n_vec++;
        if ({bus.if_rvalid_o, bus.d_rvalid_o, bus.if_gnt_o, bus.stall_o} !== 4'b0101
            || bus.d_rdata_o !== 32'h55 || bus.if_rdata_o !== 32'h0) begin
            n_err++;
            $display("FAIL both_ack got vgs=%b d_rd=%h if_rd=%h exp 0101/55/0",
                     {bus.if_rvalid_o, bus.d_rvalid_o, bus.if_gnt_o, bus.stall_o}, bus.d_rdata_o, bus.if_rdata_o);
        end
        step();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        settle();
        n_vec++;
        if ({bus.if_gnt_o, bus.d_gnt_o, bus.stall_o} !== 3'b100) begin
            n_err++;
            $display("FAIL both_if_gnt got %b exp 100", {bus.if_gnt_o, bus.d_gnt_o, bus.stall_o});
        end
        step();
        bus.if_req_i  = 1'b0;
        bus.mem_gnt_i = 1'b1;
        settle();
        n_vec++;
        if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h300}) begin
            n_err++;
            $display("FAIL both_if_payload got req=%b we=%b be=%h addr=%h exp 1/0/f/300",
                     bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o);
        end
        step();
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hCAFEF00D;
        settle();
        n_vec++;
        if ({bus.if_rvalid_o, bus.d_rvalid_o} !== 2'b10 || bus.if_rdata_o !== 32'hCAFEF00D) begin
            n_err++;
            $display("FAIL both_if_rvalid got v=%b rd=%h exp 10/cafef00d",
                     {bus.if_rvalid_o, bus.d_rvalid_o}, bus.if_rdata_o);
        end
        step();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        step();
        $display("both: store 0x200 then fetch 0x300");
    endtask

    task automatic test_streak();
        // Grant order with IF always requesting and 6 D loads queued.
        logic [7:0] exp_if_seq;
        int d_done;
        logic [31:0] exp_addr;
        exp_if_seq = 8'b1001_0000;
        d_done = 0;
        for (int i = 0; i < 8; i++) begin
            bus.if_req_i  = 1'b1;
            bus.if_addr_i = 32'h1000 + 32'(i * 4);
            bus.d_req_i   = (d_done < 6);
            bus.d_we_i    = 1'b0;
            bus.d_be_i    = 4'hF;
            bus.d_addr_i  = 32'h2000 + 32'(d_done * 4);
            exp_addr = exp_if_seq[i] ? bus.if_addr_i : bus.d_addr_i;
            settle();
            n_vec++;
            if ({bus.if_gnt_o, bus.d_gnt_o, bus.stall_o} !== {exp_if_seq[i], ~exp_if_seq[i], (d_done < 6)}) begin
                n_err++;
                $display("FAIL streak_gnt[%0d] got %b exp %b", i,
                         {bus.if_gnt_o, bus.d_gnt_o, bus.stall_o}, {exp_if_seq[i], ~exp_if_seq[i], (d_done < 6)});
            end
            $display("streak: txn %0d granted to %s", i, bus.if_gnt_o ? "IF" : "D");
            if (!exp_if_seq[i]) d_done++;
            step();
            bus.d_req_i   = (d_done < 6);
            bus.mem_gnt_i = 1'b1;
            settle();
            n_vec++;
            if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== exp_addr) begin
                n_err++;
                $display("FAIL streak_addr[%0d] got req=%b addr=%h exp 1/%h", i, bus.mem_req_o, bus.mem_addr_o, exp_addr);
            end
            if (exp_if_seq[i]) begin
                n_vec++;
                if (dut.d_streak_q !== 3'd0) begin
                    n_err++;
                    $display("FAIL streak_clear[%0d] got %0d exp 0", i, dut.d_streak_q);
                end
            end
            step();
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = 32'(i);
            settle();
            n_vec++;
            if ({bus.if_rvalid_o, bus.d_rvalid_o} !== {exp_if_seq[i], ~exp_if_seq[i]}) begin
                n_err++;
                $display("FAIL streak_rvalid[%0d] got %b exp %b", i,
                         {bus.if_rvalid_o, bus.d_rvalid_o}, {exp_if_seq[i], ~exp_if_seq[i]});
            end
            step();
            bus.mem_rvalid_i = 1'b0;
            bus.mem_rdata_i  = 32'h0;
        end
        bus.if_req_i = 1'b0;
        bus.d_req_i  = 1'b0;
        step();
    endtask

    task automatic test_gnt_stall();
        bus.d_req_i   = 1'b1;
        bus.d_we_i    = 1'b0;
        bus.d_be_i    = 4'hF;
        bus.d_addr_i  = 32'h400;
        bus.d_wdata_i = 32'h0;
        settle();
        n_vec++;
        if ({bus.if_gnt_o, bus.d_gnt_o, bus.stall_o} !== 3'b010) begin
            n_err++;
            $display("FAIL hold_gnt got %b exp 010", {bus.if_gnt_o, bus.d_gnt_o, bus.stall_o});
        end
        step();
        // A new D request with different payload arrives while the port is busy.
        bus.d_addr_i = 32'hFFFF_FFFF;
        bus.d_be_i   = 4'h0;
        for (int k = 0; k < 5; k++) begin
            settle();
            n_vec++;
            if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h400}
                || {bus.if_gnt_o, bus.d_gnt_o, bus.stall_o} !== 3'b001) begin
                n_err++;
                $display("FAIL hold_cycle[%0d] got req=%b we=%b be=%h addr=%h gs=%b exp 1/0/f/400/001", k,
                         bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o,
                         {bus.if_gnt_o, bus.d_gnt_o, bus.stall_o});
            end
            step();
        end
        bus.d_req_i   = 1'b0;
        bus.mem_gnt_i = 1'b1;
        step();
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hA5A5A5A5;
        settle();
        n_vec++;
        if ({bus.if_rvalid_o, bus.d_rvalid_o} !== 2'b01 || bus.d_rdata_o !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL hold_rvalid got v=%b rd=%h exp 01/a5a5a5a5", {bus.if_rvalid_o, bus.d_rvalid_o}, bus.d_rdata_o);
        end
        step();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        bus.d_addr_i     = 32'h0;
        step();
        $display("gnt_stall: load 0x400 held 5 cycles");
    endtask

    task automatic test_reset_in_wait();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h500;
        step();
        bus.if_req_i  = 1'b0;
        bus.mem_gnt_i = 1'b1;
        step();
        bus.mem_gnt_i = 1'b0;
        rst_ni        = 1'b0;
        bus.if_req_i  = 1'b1;
        bus.d_req_i   = 1'b1;
        settle();
        n_vec++;
        if ({bus.if_gnt_o, bus.d_gnt_o, bus.if_rvalid_o, bus.d_rvalid_o, bus.mem_req_o, bus.stall_o} !== 6'b0
            || {bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !== 69'd0) begin
            n_err++;
            $display("FAIL rst_wait_outputs got ctrl=%b payload=%h exp 0/0",
                     {bus.if_gnt_o, bus.d_gnt_o, bus.if_rvalid_o, bus.d_rvalid_o, bus.mem_req_o, bus.stall_o},
                     {bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o});
        end
        step();
        rst_ni           = 1'b1;
        bus.if_req_i     = 1'b0;
        bus.d_req_i      = 1'b0;
        stray_ok         = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hBAD0BAD0;
        settle();
        n_vec++;
        if ({bus.if_rvalid_o, bus.d_rvalid_o, bus.mem_req_o} !== 3'b000 || dut.state_q !== IDLE) begin
            n_err++;
            $display("FAIL rst_wait_late got v=%b req=%b state=%0d exp 00/0/IDLE",
                     {bus.if_rvalid_o, bus.d_rvalid_o}, bus.mem_req_o, dut.state_q);
        end
        step();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        stray_ok         = 1'b0;
        settle();
        n_vec++;
        if (dut.state_q !== IDLE || bus.mem_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL rst_wait_idle got state=%0d req=%b exp IDLE/0", dut.state_q, bus.mem_req_o);
        end
        step();
        $display("reset_in_wait: late response dropped");
    endtask

    task automatic test_stray_idle();
        stray_ok         = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h1234;
        settle();
        n_vec++;
        if ({bus.if_rvalid_o, bus.d_rvalid_o} !== 2'b00 || {bus.if_rdata_o, bus.d_rdata_o} !== 64'd0) begin
            n_err++;
            $display("FAIL stray_rvalid got v=%b if_rd=%h d_rd=%h exp 00/0/0",
                     {bus.if_rvalid_o, bus.d_rvalid_o}, bus.if_rdata_o, bus.d_rdata_o);
        end
        step();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        stray_ok         = 1'b0;
        settle();
        n_vec++;
        if (dut.state_q !== IDLE || bus.mem_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL stray_state got state=%0d req=%b exp IDLE/0", dut.state_q, bus.mem_req_o);
        end
        step();
        $display("stray_idle: response ignored");
    endtask

    initial begin
        bus.if_req_i     = 1'b0;
        bus.if_addr_i    = 32'h0;
        bus.d_req_i      = 1'b0;
        bus.d_we_i       = 1'b0;
        bus.d_be_i       = 4'h0;
        bus.d_addr_i     = 32'h0;
        bus.d_wdata_i    = 32'h0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        test_reset();
        test_if_only();
        test_both();
        test_streak();
        test_gnt_stall();
        test_reset_in_wait();
        test_stray_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
